// File: rtl/mul_pkg.sv
// Shared definitions for the iterative unsigned multiplier.
//   mul_state_t : controller state encoding (IDLE, BUSY, DONE)
//   MUL_WIDTH   : default operand width
//   MUL_CNT_W   : iteration counter width for the default operand width
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mulu_1iter.sv
// One shift-and-add step of the unsigned multiplier (purely combinational).
//   acc, mcand     : 2*WIDTH accumulator and shifted multiplicand
//   mplier         : WIDTH multiplier, LSB selects whether mcand is added
//   acc_nx, mcand_nx, mplier_nx : values after this step
module mulu_1iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [2*WIDTH-1:0] mcand_nx,
  output logic [WIDTH-1:0]   mplier_nx
);

  always_comb begin
    // Carry-out of the add is dropped: the final result never exceeds
    // 2^(2W) - 2^W, so it cannot occur.
    acc_nx    = mplier[0] ? (acc + mcand) : acc;
    mcand_nx  = mcand << 1;
    mplier_nx = mplier >> 1;
  end

endmodule

// File: rtl/multiplier_unsigned_seq.sv
// Iterative unsigned multiply-add: o_product = i_multiplicand * i_multiplier
// + i_addend, one multiplier bit per cycle, fixed latency of WIDTH cycles.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its data stable until that edge. Operands
// are taken on i_valid && o_ready; the result is released on o_valid &&
// i_ready. o_ready is high only in IDLE, o_valid only in DONE.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_valid/o_ready: operand handshake
//   i_multiplicand, i_multiplier, i_addend : WIDTH-bit operands
//   o_valid/i_ready: result handshake
//   o_product      : 2*WIDTH-bit result, held after the result is taken
module multiplier_unsigned_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic [WIDTH-1:0]   i_addend,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = (WIDTH == MUL_WIDTH) ? MUL_CNT_W : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t          state_q, state_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;

  logic [2*WIDTH-1:0]  acc_nx;
  logic [2*WIDTH-1:0]  mcand_nx;
  logic [WIDTH-1:0]    mplier_nx;

  mulu_1iter #(.WIDTH(WIDTH)) u_iter (
    .acc       (acc_q),
    .mcand     (mcand_q),
    .mplier    (mplier_q),
    .acc_nx    (acc_nx),
    .mcand_nx  (mcand_nx),
    .mplier_nx (mplier_nx)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)          state_d = BUSY;
      BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (i_ready)          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          acc_d    = {{WIDTH{1'b0}}, i_addend};
          mcand_d  = {{WIDTH{1'b0}}, i_multiplicand};
          mplier_d = i_multiplier;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_nx;
        mplier_d = mplier_nx;
        cnt_d    = cnt_q + 1'b1;
        // The result register is loaded only on the final step so that
        // o_product keeps the previous result until a new one is ready.
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          prod_d = acc_nx;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    o_ready   = (state_q == IDLE);
    o_valid   = (state_q == DONE);
    o_product = prod_q;
  end

endmodule

// File: tb/tb_multiplier_unsigned_seq.sv
module tb_multiplier_unsigned_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [W-1:0]   addend;
    logic [2*W-1:0] exp;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic           i_valid;
  logic           o_ready;
  logic [W-1:0]   i_multiplicand;
  logic [W-1:0]   i_multiplier;
  logic [W-1:0]   i_addend;
  logic           o_valid;
  logic           i_ready;
  logic [2*W-1:0] o_product;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];

  multiplier_unsigned_seq #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_addend       (i_addend),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_product      (o_product)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Step one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present operands and complete the input handshake.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c);
    chk("ready_before_send", {63'd0, o_ready}, 64'd1);
    i_valid        = 1'b1;
    i_multiplicand = a;
    i_multiplier   = b;
    i_addend       = c;
    exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b} + {{W{1'b0}}, c});
    step();
    i_valid = 1'b0;
  endtask

  // Wait for o_valid with a bounded budget; optionally disturb the inputs
  // while the unit is busy. Returns the cycles since the handshake edge.
  task automatic wait_valid(input bit noisy, output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (o_valid) begin
        lat = k - 1;
        break;
      end
      if (noisy) begin
        chk("busy_not_ready", {63'd0, o_ready}, 64'd0);
        i_valid        = 1'($urandom_range(0, 1));
        i_multiplicand = $urandom;
        i_multiplier   = $urandom;
        i_addend       = $urandom;
      end
      step();
    end
    i_valid = 1'b0;
    if (!o_valid) begin
      errors++;
      checks++;
      $display("FAIL timeout waiting for o_valid");
    end
  endtask

  // Scoreboard: compare the result against the oldest expected value.
  task automatic check_result(input string name);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s no expected value queued", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, o_product, e);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c,
                        input bit noisy);
    int lat;
    send(a, b, c);
    wait_valid(noisy, lat);
    chk({name, "_latency"}, 64'(lat), 64'd32);
    check_result(name);
    step();
    chk({name, "_idle_ready"}, {62'd0, o_ready, o_valid}, 64'd2);
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    logic [2*W-1:0] held;
    logic [W-1:0] dvd, dvs, quo, rem;

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_multiplicand = '0;
    i_multiplier = '0;
    i_addend = '0;

    vecs[0] = '{32'd7, 32'd6, 32'd0, 64'd42};
    vecs[1] = '{32'd7, 32'd14, 32'd3, 64'd101};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000};
    vecs[3] = '{32'd123, 32'd0, 32'd5, 64'd5};
    vecs[4] = '{32'd1, 32'd1, 32'd0, 64'd1};
    vecs[5] = '{32'h00010000, 32'h00010000, 32'd0, 64'h1_0000_0000};
    vecs[6] = '{32'hFFFFFFFF, 32'd2, 32'd1, 64'h1_FFFF_FFFF};
    vecs[7] = '{32'd12345, 32'd1000, 32'd7, 64'd12345007};
    vecs[8] = '{32'h80000000, 32'h80000000, 32'd0, 64'h4000_0000_0000_0000};
    vecs[9] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 64'h1_FFFF_FFFE};

    // Reset state
    #12;
    chk("reset_ready", {63'd0, o_ready}, 64'd1);
    chk("reset_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_product", o_product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_hold", {62'd0, o_ready, o_valid}, 64'd2);
    end

    // Table-driven vectors; expected values are the hand-computed ones.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].mcand, vecs[i].mplier, vecs[i].addend);
      void'(exp_q.pop_back());
      exp_q.push_back(vecs[i].exp);
      wait_valid(1'b0, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      check_result($sformatf("vec%0d_product", i));
      step();
      chk($sformatf("vec%0d_back_idle", i), {62'd0, o_ready, o_valid}, 64'd2);
      chk($sformatf("vec%0d_product_held", i), o_product, vecs[i].exp);
    end

    // Backpressure: result held stable while i_ready is low.
    i_ready = 1'b0;
    send(32'd1000, 32'd2000, 32'd9);
    wait_valid(1'b0, lat);
    chk("bp_latency", 64'(lat), 64'd32);
    held = o_product;
    check_result("bp_product");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid_stable", {62'd0, o_ready, o_valid}, 64'd1);
      chk("bp_product_stable", o_product, held);
    end
    i_ready = 1'b1;
    step();
    chk("bp_released", {62'd0, o_ready, o_valid}, 64'd2);

    // Operand changes and stray i_valid during BUSY are ignored.
    run_op("noisy_busy", 32'hDEADBEEF, 32'h12345678, 32'h0000ABCD, 1'b1);

    // Reset in the middle of BUSY.
    send(32'd99, 32'd77, 32'd1);
    void'(exp_q.pop_back());
    for (int i = 0; i < 15; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, o_ready}, 64'd1);
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_product", o_product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit late_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (o_valid) late_valid = 1'b1;
      end
      chk("midrst_no_late_valid", {63'd0, late_valid}, 64'd0);
    end
    run_op("after_reset_3x5p1", 32'd3, 32'd5, 32'd1, 1'b0);
    chk("after_reset_value", o_product, 64'd16);

    // Divider inverse: quotient*divisor + remainder rebuilds the dividend.
    for (int i = 0; i < 1000; i++) begin
      int lat2;
      dvd = $urandom;
      dvs = $urandom_range(1, 32'hFFFF) << $urandom_range(0, 16);
      if (dvs == 0) dvs = 1;
      quo = dvd / dvs;
      rem = dvd % dvs;
      send(dvs, quo, rem);
      void'(exp_q.pop_back());
      exp_q.push_back({{W{1'b0}}, dvd});
      wait_valid(1'b0, lat2);
      check_result("div_inverse");
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_unsigned_seq.md
Name: multiplier_unsigned_seq

Overview:
- Iterative unsigned shift-and-add unit; the inverse of the team's combinational unsigned divider.
- Computes o_product = i_multiplicand * i_multiplier + i_addend.
- Feeding a divider's quotient, divisor and remainder back in rebuilds the dividend, so the block serves both as the MUL/MULHU datapath and as the divider's self-check path.
- Sits in the execute stage behind a valid/ready handshake; one bit per cycle.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_multiplicand  input  WIDTH  e.g. divisor.
- i_multiplier  input  WIDTH  e.g. quotient.
- i_addend  input  WIDTH  e.g. remainder; zero-extended before the add.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_product  output  2*WIDTH  multiplicand*multiplier + addend.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - State IDLE; o_ready=1, o_valid=0, o_product=0.
  - Internal accumulator, multiplicand shift register, multiplier shift register and counter all 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid && o_ready, capture registers:
    - acc = {WIDTH'0, i_addend}
    - mcand = {WIDTH'0, i_multiplicand}
    - mplier = i_multiplier
    - cnt = 0
  - Go to BUSY.
  - Inputs are sampled only at this handshake; later changes are ignored.
- BUSY, one iteration per cycle:
  - if mplier[0], acc = acc + mcand (2*WIDTH-bit add, carry-out discarded; it never occurs);
  - mcand = mcand << 1; mplier = mplier >> 1; cnt++;
  - when cnt == WIDTH-1 on this cycle, go to DONE.
  - o_ready=0, o_valid=0.
- Fixed latency: handshake at edge N -> o_valid high after edge N+WIDTH (32 BUSY cycles). No early termination, even for zero operands, so latency is deterministic.
- DONE:
  - o_valid=1 and o_product=acc, both held stable until i_valid... no — until i_ready is high.
  - On o_valid && i_ready: return to IDLE, o_valid=0. o_product keeps its last value (it is not cleared).
  - o_ready=0 in DONE; a new operation cannot start in the same cycle the result is taken (no overlap).
- Width rule: max result (2^W-1)^2 + (2^W-1) = 2^2W - 2^W, which always fits in 2*WIDTH bits; no overflow flag.
- Backpressure: i_ready low in DONE stalls indefinitely with outputs stable.
- i_valid while BUSY or DONE: ignored; the upstream holds it since o_ready=0.
- Reset mid-operation (BUSY or DONE): immediately returns to the reset state; the partial result is discarded and no o_valid pulse is produced.
- i_ready in IDLE/BUSY: don't care.

Decomposition:
- Shared package mul_pkg:
  - typedef enum mul_state_t {IDLE, BUSY, DONE};
  - localparam default WIDTH=32 and a counter-width constant $clog2(WIDTH).
- One natural combinational sub-module: mulu_1iter.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, next mcand, next mplier.
  - Performs one shift-add step; instantiated once, with state registers in the parent.
  - Mirrors the divider's one-iteration cell so both can be unit-tested alone.

Test Plan:
- Reset/idle: assert rst_n=0 then release -> o_ready=1, o_valid=0, o_product=0; no activity without i_valid.
- Basic multiply: multiplicand=7, multiplier=6, addend=0, i_ready=1 -> o_valid exactly 32 cycles after handshake, o_product=42, then back to IDLE with o_ready=1 next cycle.
- Divider inverse: multiplicand=7 (divisor), multiplier=14 (quotient), addend=3 (remainder) -> o_product=101. Random sweep of 1000 pairs through the combinational divider and back -> low word equals the original dividend, high word equals 0.
- Max operands: all three inputs 32'hFFFFFFFF -> o_product=64'hFFFFFFFF_00000000. Multiplier=0, addend=5 -> o_product=5 after the full 32-cycle latency.
- Backpressure and input stability:
  - hold i_ready=0 for 10 cycles in DONE -> o_valid and o_product stable;
  - toggle the operand inputs during BUSY -> result unaffected;
  - i_valid asserted during BUSY -> not accepted.
- Reset mid-operation: drop rst_n at cycle 15 of BUSY -> immediate IDLE with o_valid=0 and no late o_valid; a following operation of 3*5+1 -> 16 with correct latency.
